s2mm_ring_ctrl: RTL and testbench
=================================

# s2mm_ring_ctrl

Parametrised command sequencer for the AXI DataMover S2MM channel. It writes a continuous stream into a circular DDR buffer by issuing fixed-size write commands, keeping several commands in flight, wrapping at the end of the buffer, and checking every status beat. It sits between the capture FIFO and the datamover command/status ports in `top`, and exports a fill pointer and error counters for readback logic.

## Interface
- `ADDR_W`, 32: DDR byte-address width.
- `BTT_W`, 23: bytes-to-transfer field width; fixed by the DataMover command format.
- `MAX_OUT`, 4: maximum number of commands in flight, 1..15.
- `clk` in 1: single clock domain.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: run request. Sampled every cycle.
- `ring_base` in ADDR_W: buffer start byte address. Latched on start.
- `ring_size` in ADDR_W: buffer length in bytes. Must be a nonzero multiple of `btt`. Latched on start.
- `btt` in BTT_W: bytes per command. Nonzero. Latched on start.
- `cmd_tdata` out ADDR_W+40: packed as {4'b0, tag[3:0], addr, 8'h00, 1'b1 (INCR), btt}.
- `cmd_tvalid` out 1, `cmd_tready` in 1: AXI-Stream command handshake.
- `sts_tdata` in 8: bit 7 OKAY, bit 6 SLVERR, bit 5 DECERR, bit 4 INTERR, bits 3:0 TAG.
- `sts_tvalid` in 1, `sts_tready` out 1: status handshake.
- `busy` out 1: state is not IDLE.
- `fill_ptr` out ADDR_W: byte address one past the last successfully completed block.
- `blocks_done` out 32: count of good completions. Wraps modulo 2^32.
- `err_count` out 16: count of bad completions. Saturates at 0xFFFF.
- `err` out 1: sticky flag. Cleared only on start.

## Operation
- States:
  - IDLE: waits for `enable`=1. On that, it enters ISSUE, latches the config, clears `offset`, `tag`, `exp_tag` and `err`, and sets `fill_ptr`=`ring_base`.
  - ISSUE: issues commands while `enable`=1. When `enable`=0, it goes to DRAIN.
  - DRAIN: issues nothing new. When `outstanding`=0 and no command is pending, it goes to IDLE.
- A command presented on `cmd_tvalid` is never withdrawn. In DRAIN, a pending command stays valid until accepted and is then counted as outstanding.
- Issue condition: in ISSUE with `outstanding` < MAX_OUT, counting the same-cycle status retire.
- Command address is `ring_base` + `offset`. On accept:
  - `offset` += `btt`; if the result equals `ring_size`, `offset` wraps to 0.
  - `tag` = `tag`+1 mod 16.
- Outstanding counter:
  - Accept only: +1. Status only: -1. Both in the same cycle: unchanged.
  - A status beat with `outstanding`=0 counts as an error and leaves the counter at 0.
- Status is expected in order.
  - Good completion: OKAY=1, bits 6:4 all 0, and TAG = `exp_tag`. On good: `blocks_done`+1, `fill_ptr` advances by `btt` with the same wrap rule.
  - Anything else is bad. On bad: `err_count`+1 (saturating), `err`=1, `fill_ptr` held.
  - `exp_tag`+1 on every status beat.
- `sts_tready` = 1 whenever not in reset.
- Width rules: `offset` arithmetic is ADDR_W bits. `btt` is zero-extended.

## Timing
- All outputs are registered.
- Reset values: `cmd_tvalid`=0, `cmd_tdata`=0, `sts_tready`=0, `busy`=0, `fill_ptr`=0, `blocks_done`=0, `err_count`=0, `err`=0, state IDLE.
- `enable` rising in IDLE: `busy`=1 on the next edge, first `cmd_tvalid`=1 one edge later. Start-to-valid is 2 cycles.
- After accept with headroom, the next `cmd_tvalid` follows in the next cycle, allowing back-to-back commands.
- A status beat updates the counters and `fill_ptr` on the following edge.
- Reset mid-operation: immediate return to reset values. In-flight datamover transfers are abandoned; the system resets the datamover alongside.

## Structure
- Package `s2mm_pkg` holds:
  - the state enum `s2mm_state_t`;
  - status bit-index constants;
  - the fixed field constants (type INCR, DRR/EOF byte 8'h00);
  - function `s2mm_cmd_pack(tag, addr, btt)`.
- No sub-module. A single `always_ff` plus next-state logic; expected size 150–250 lines.

## Test plan
- Basic run: `ring_base`=0x1000_0000, `ring_size`=0x4000, `btt`=0x1000, `cmd_tready`=1, status OKAY echoed 10 cycles after each accept. Expect addresses 0x1000_0000, 1000, 2000, 3000, then 0x1000_0000 again; tags 0,1,2,3,4; `fill_ptr` wraps to 0x1000_0000 after the 4th status.
- Flow limit: MAX_OUT=4, status withheld. Expect exactly 4 accepts and then `cmd_tvalid`=0. One status releases exactly one more command.
- Simultaneous accept and status in the same cycle: `outstanding` unchanged, `blocks_done`+1.
- Error: status 0xC2 (OKAY+SLVERR), then a status with a wrong tag. Expect `err_count`=2, `err`=1, `fill_ptr` held, and sequencing continues.
- Stop: drop `enable` with 3 outstanding and one command pending under `cmd_tready`=0. Expect the pending command is held and then accepted, `busy` stays 1 until 4 statuses return, then IDLE.
- Reset: assert `reset` asynchronously mid-ISSUE. Expect all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/s2mm_pkg.sv
// Shared types, status bit positions and command packing for the S2MM ring sequencer.
package s2mm_pkg;

  localparam int unsigned S2MM_ADDR_W = 32;
  localparam int unsigned S2MM_BTT_W  = 23;
  localparam int unsigned S2MM_CMD_W  = S2MM_ADDR_W + 40;

  // Status beat bit positions
  localparam int unsigned STS_OKAY   = 7;
  localparam int unsigned STS_SLVERR = 6;
  localparam int unsigned STS_DECERR = 5;
  localparam int unsigned STS_INTERR = 4;

  // Fixed command fields: INCR burst type, no DRR/EOF flags
  localparam logic       CMD_TYPE_INCR = 1'b1;
  localparam logic [7:0] CMD_DRR_EOF   = 8'h00;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain
  } s2mm_state_t;

  // {4'b0, tag, addr, 8'h00, INCR, btt}
  function automatic logic [S2MM_CMD_W-1:0] s2mm_cmd_pack(input logic [3:0]             tag,
                                                          input logic [S2MM_ADDR_W-1:0] addr,
                                                          input logic [S2MM_BTT_W-1:0]  btt);
    return {4'b0000, tag, addr, CMD_DRR_EOF, CMD_TYPE_INCR, btt};
  endfunction

endpackage

// File: rtl/s2mm_ring_ctrl.sv
// Issues fixed-size DataMover S2MM write commands around a circular DDR buffer, keeps up to
// MAX_OUT commands in flight and checks in-order status beats.
module s2mm_ring_ctrl
  import s2mm_pkg::*;
#(
  parameter int unsigned ADDR_W  = S2MM_ADDR_W,
  parameter int unsigned BTT_W   = S2MM_BTT_W,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic [ADDR_W-1:0] i_ring_base,
  input  logic [ADDR_W-1:0] i_ring_size,
  input  logic [BTT_W-1:0]  i_btt,
  output logic [ADDR_W+39:0] o_cmd_tdata,
  output logic              o_cmd_tvalid,
  input  logic              i_cmd_tready,
  input  logic [7:0]        i_sts_tdata,
  input  logic              i_sts_tvalid,
  output logic              o_sts_tready,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_fill_ptr,
  output logic [31:0]       o_blocks_done,
  output logic [15:0]       o_err_count,
  output logic              o_err
);

  localparam logic [3:0] OUT_MAX = 4'(MAX_OUT);

  s2mm_state_t        r_state, w_state_d;
  logic [ADDR_W-1:0]  r_base, w_base_d, r_size, w_size_d;
  logic [BTT_W-1:0]   r_btt, w_btt_d;
  logic [ADDR_W-1:0]  r_offset, w_offset_d, r_fill_off, w_fill_off_d, r_fill_ptr, w_fill_ptr_d;
  logic [3:0]         r_tag, w_tag_d, r_exp_tag, w_exp_tag_d, r_out, w_out_d;
  logic               r_cmd_valid, w_cmd_valid_d;
  logic [ADDR_W+39:0] r_cmd_data, w_cmd_data_d;
  logic               r_sts_ready, r_busy;
  logic [31:0]        r_blocks, w_blocks_d;
  logic [15:0]        r_err_count, w_err_count_d;
  logic               r_err, w_err_d;

  logic              w_accept, w_sts_beat, w_retire, w_sts_good;
  logic [ADDR_W-1:0] w_btt_ext, w_off_sum, w_fill_sum;

  assign w_accept   = r_cmd_valid & i_cmd_tready;
  assign w_sts_beat = i_sts_tvalid & r_sts_ready;
  // A beat with nothing outstanding is an error and must not underflow the counter
  assign w_retire   = w_sts_beat & (r_out != 4'd0);
  assign w_sts_good = w_retire & i_sts_tdata[STS_OKAY] & ~i_sts_tdata[STS_SLVERR] &
                      ~i_sts_tdata[STS_DECERR] & ~i_sts_tdata[STS_INTERR] &
                      (i_sts_tdata[3:0] == r_exp_tag);
  assign w_btt_ext  = {{(ADDR_W - BTT_W){1'b0}}, r_btt};
  assign w_off_sum  = r_offset + w_btt_ext;
  assign w_fill_sum = r_fill_off + w_btt_ext;

  // Next-state: command issue, status accounting and run-state sequencing
  always_comb begin
    w_state_d     = r_state;
    w_base_d      = r_base;
    w_size_d      = r_size;
    w_btt_d       = r_btt;
    w_offset_d    = r_offset;
    w_fill_off_d  = r_fill_off;
    w_fill_ptr_d  = r_fill_ptr;
    w_tag_d       = r_tag;
    w_exp_tag_d   = r_exp_tag;
    w_out_d       = r_out + {3'b000, w_accept} - {3'b000, w_retire};
    w_cmd_valid_d = r_cmd_valid & ~w_accept;
    w_cmd_data_d  = r_cmd_data;
    w_blocks_d    = r_blocks;
    w_err_count_d = r_err_count;
    w_err_d       = r_err;

    if (w_accept) begin
      w_offset_d = (w_off_sum == r_size) ? '0 : w_off_sum;
      w_tag_d    = r_tag + 4'd1;
    end

    if (w_sts_beat) begin
      w_exp_tag_d = r_exp_tag + 4'd1;
      if (w_sts_good) begin
        w_blocks_d   = r_blocks + 32'd1;
        w_fill_off_d = (w_fill_sum == r_size) ? '0 : w_fill_sum;
        w_fill_ptr_d = r_base + w_fill_off_d;
      end else begin
        if (r_err_count != 16'hFFFF) w_err_count_d = r_err_count + 16'd1;
        w_err_d = 1'b1;
      end
    end

    unique case (r_state)
      StIdle: begin
        if (i_enable) begin
          w_state_d    = StIssue;
          w_base_d     = i_ring_base;
          w_size_d     = i_ring_size;
          w_btt_d      = i_btt;
          w_offset_d   = '0;
          w_tag_d      = 4'd0;
          w_exp_tag_d  = 4'd0;
          w_err_d      = 1'b0;
          w_fill_off_d = '0;
          w_fill_ptr_d = i_ring_base;
        end
      end
      StIssue: begin
        if (!i_enable) begin
          w_state_d = StDrain;
        end else if ((!r_cmd_valid || w_accept) && (w_out_d < OUT_MAX)) begin
          // Headroom counts this cycle's accept and retire, so back-to-back issue is possible
          w_cmd_valid_d = 1'b1;
          w_cmd_data_d  = s2mm_cmd_pack(w_tag_d, r_base + w_offset_d, r_btt);
        end
      end
      StDrain: begin
        if ((r_out == 4'd0) && !r_cmd_valid) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_base      <= '0;
      r_size      <= '0;
      r_btt       <= '0;
      r_offset    <= '0;
      r_fill_off  <= '0;
      r_fill_ptr  <= '0;
      r_tag       <= 4'd0;
      r_exp_tag   <= 4'd0;
      r_out       <= 4'd0;
      r_cmd_valid <= 1'b0;
      r_cmd_data  <= '0;
      r_sts_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_blocks    <= '0;
      r_err_count <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_base      <= w_base_d;
      r_size      <= w_size_d;
      r_btt       <= w_btt_d;
      r_offset    <= w_offset_d;
      r_fill_off  <= w_fill_off_d;
      r_fill_ptr  <= w_fill_ptr_d;
      r_tag       <= w_tag_d;
      r_exp_tag   <= w_exp_tag_d;
      r_out       <= w_out_d;
      r_cmd_valid <= w_cmd_valid_d;
      r_cmd_data  <= w_cmd_data_d;
      r_sts_ready <= 1'b1;
      r_busy      <= (w_state_d != StIdle);
      r_blocks    <= w_blocks_d;
      r_err_count <= w_err_count_d;
      r_err       <= w_err_d;
    end
  end

  assign o_cmd_tdata   = r_cmd_data;
  assign o_cmd_tvalid  = r_cmd_valid;
  assign o_sts_tready  = r_sts_ready;
  assign o_busy        = r_busy;
  assign o_fill_ptr    = r_fill_ptr;
  assign o_blocks_done = r_blocks;
  assign o_err_count   = r_err_count;
  assign o_err         = r_err;

endmodule

// File: tb/tb_s2mm_ring_ctrl.sv
// Directed and randomized bench for s2mm_ring_ctrl against a transaction-level ring model.
module tb_s2mm_ring_ctrl;

  localparam int ADDR_W  = 32;
  localparam int BTT_W   = 23;
  localparam int MAX_OUT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_enable;
  logic [31:0]       i_ring_base, i_ring_size;
  logic [22:0]       i_btt;
  logic [71:0]       o_cmd_tdata;
  logic              o_cmd_tvalid, i_cmd_tready;
  logic [7:0]        i_sts_tdata;
  logic              i_sts_tvalid, o_sts_tready;
  logic              o_busy, o_err;
  logic [31:0]       o_fill_ptr, o_blocks_done;
  logic [15:0]       o_err_count;

  always #5 clk = ~clk;

  s2mm_ring_ctrl #(.ADDR_W(ADDR_W), .BTT_W(BTT_W), .MAX_OUT(MAX_OUT)) dut (
    .i_clk(clk), .i_reset(reset), .i_enable(i_enable), .i_ring_base(i_ring_base),
    .i_ring_size(i_ring_size), .i_btt(i_btt), .o_cmd_tdata(o_cmd_tdata),
    .o_cmd_tvalid(o_cmd_tvalid), .i_cmd_tready(i_cmd_tready), .i_sts_tdata(i_sts_tdata),
    .i_sts_tvalid(i_sts_tvalid), .o_sts_tready(o_sts_tready), .o_busy(o_busy),
    .o_fill_ptr(o_fill_ptr), .o_blocks_done(o_blocks_done), .o_err_count(o_err_count),
    .o_err(o_err)
  );

  int n_pass = 0, n_total = 0;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference model of the ring, tags and completion counters
  longint unsigned m_base, m_size, m_btt, m_off, m_fill_off;
  int              m_tag, m_exp, m_errc;
  logic [31:0]     m_blocks, m_fill_ptr;
  bit              m_err;
  int              q_tag[$], q_due[$], bad_q[$];
  int              ready_mode, sts_budget, lat_fix, err_pct, cyc, accepts, n_sts;
  bit              lat_rand, prev_stall, fill4_seen;
  logic [71:0]     prev_data;
  logic [31:0]     acc_addr[$], fill4;
  int              acc_tag[$];

  function automatic longint unsigned ring_next(input longint unsigned off);
    longint unsigned r;
    r = off + m_btt;
    return (r == m_size) ? 0 : r;
  endfunction

  function automatic logic [71:0] exp_cmd();
    logic [31:0] a;
    a = 32'(m_base + m_off);
    return {4'b0000, 4'(m_tag), a, 8'h00, 1'b1, 23'(m_btt)};
  endfunction

  task automatic model_clear();
    m_blocks = '0; m_errc = 0; m_err = 0; m_fill_ptr = '0;
    q_tag.delete(); q_due.delete(); prev_stall = 0;
  endtask

  // One clock: drive at negedge, score at negedge, check registered outputs after the edge
  task automatic cycle();
    logic [7:0] s;
    int         kind;
    bit         good;
    @(negedge clk);
    i_cmd_tready = (ready_mode == 1) ? 1'b1 :
                   (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    i_sts_tvalid = 1'b0;
    i_sts_tdata  = 8'h00;
    if (sts_budget != 0 && q_tag.size() > 0 && q_due[0] <= cyc) begin
      s    = {4'h8, 4'(q_tag[0])};
      kind = 0;
      if (bad_q.size() > 0) kind = bad_q.pop_front();
      else if (err_pct > 0 && $urandom_range(0, 99) < err_pct) kind = $urandom_range(1, 3);
      case (kind)
        1: s[6] = 1'b1;
        2: s[3:0] = s[3:0] + 4'd1;
        3: s[7] = 1'b0;
        default: ;
      endcase
      i_sts_tvalid = 1'b1;
      i_sts_tdata  = s;
      void'(q_tag.pop_front());
      void'(q_due.pop_front());
      if (sts_budget > 0) sts_budget--;
      n_sts++;
      good  = s[7] && (s[6:4] == 3'b000) && (s[3:0] == 4'(m_exp));
      m_exp = (m_exp + 1) % 16;
      if (good) begin
        m_blocks++;
        m_fill_off = ring_next(m_fill_off);
        m_fill_ptr = 32'(m_base + m_fill_off);
      end else begin
        if (m_errc < 16'hFFFF) m_errc++;
        m_err = 1;
      end
    end
    if (prev_stall) begin
      chk("cmd_held_valid", 72'(o_cmd_tvalid), 72'(1));
      chk("cmd_held_data", o_cmd_tdata, prev_data);
    end
    if (o_cmd_tvalid && i_cmd_tready) begin
      chk("cmd_data", o_cmd_tdata, exp_cmd());
      acc_addr.push_back(o_cmd_tdata[63:32]);
      acc_tag.push_back(int'(o_cmd_tdata[67:64]));
      q_tag.push_back(m_tag);
      q_due.push_back(cyc + (lat_rand ? int'($urandom_range(1, 8)) : lat_fix));
      m_tag = (m_tag + 1) % 16;
      m_off = ring_next(m_off);
      accepts++;
    end
    prev_stall = o_cmd_tvalid && !i_cmd_tready;
    prev_data  = o_cmd_tdata;
    @(posedge clk);
    #1;
    cyc++;
    chk("fill_ptr", 72'(o_fill_ptr), 72'(m_fill_ptr));
    chk("blocks_done", 72'(o_blocks_done), 72'(m_blocks));
    chk("err_count", 72'(o_err_count), 72'(16'(m_errc)));
    chk("err_flag", 72'(o_err), 72'(m_err));
    chk("inflight_le_max", 72'(q_tag.size() <= MAX_OUT), 72'(1));
    if (n_sts == 4 && !fill4_seen) begin
      fill4_seen = 1;
      fill4      = o_fill_ptr;
    end
  endtask

  task automatic start(input logic [31:0] base, input logic [31:0] size, input logic [22:0] b);
    @(negedge clk);
    i_ring_base = base; i_ring_size = size; i_btt = b; i_enable = 1'b1;
    i_cmd_tready = 1'b0; i_sts_tvalid = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    m_base = base; m_size = size; m_btt = b; m_off = 0; m_tag = 0; m_exp = 0; m_err = 0;
    m_fill_off = 0; m_fill_ptr = base; prev_stall = 0;
    acc_addr.delete(); acc_tag.delete();
    chk("start_busy", 72'(o_busy), 72'(1));
    chk("start_valid_low", 72'(o_cmd_tvalid), 72'(0));
    chk("start_fill", 72'(o_fill_ptr), 72'(base));
    // Config must have been latched; scramble the inputs
    i_ring_base = $urandom; i_ring_size = $urandom; i_btt = 23'($urandom);
    @(negedge clk);
    @(posedge clk);
    #1;
    cyc++;
    chk("start_valid_2cyc", 72'(o_cmd_tvalid), 72'(1));
  endtask

  initial begin
    logic [31:0] exp_a[5];
    logic [31:0] b0, f0, rb, rs;
    logic [15:0] e0;
    logic [22:0] rbtt;
    int          a0, s0, g;

    exp_a = '{32'h1000_0000, 32'h1000_1000, 32'h1000_2000, 32'h1000_3000, 32'h1000_0000};
    reset = 1'b1; i_enable = 1'b0; i_ring_base = '0; i_ring_size = '0; i_btt = '0;
    i_cmd_tready = 1'b0; i_sts_tvalid = 1'b0; i_sts_tdata = 8'h00;
    ready_mode = 0; sts_budget = -1; lat_fix = 10; lat_rand = 0; err_pct = 0;
    cyc = 0; accepts = 0; n_sts = 0; fill4_seen = 0; fill4 = '0; m_exp = 0; m_tag = 0;
    model_clear();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_tvalid", 72'(o_cmd_tvalid), 72'(0));
    chk("rst_cmd_tdata", o_cmd_tdata, 72'(0));
    chk("rst_sts_tready", 72'(o_sts_tready), 72'(0));
    chk("rst_busy", 72'(o_busy), 72'(0));
    chk("rst_fill_ptr", 72'(o_fill_ptr), 72'(0));
    chk("rst_blocks", 72'(o_blocks_done), 72'(0));
    chk("rst_err_count", 72'(o_err_count), 72'(0));
    chk("rst_err", 72'(o_err), 72'(0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("sts_tready_up", 72'(o_sts_tready), 72'(1));

    // Basic run: 4-block ring, status echoed 10 cycles after each accept
    ready_mode = 1;
    start(32'h1000_0000, 32'h0000_4000, 23'h1000);
    repeat (40) cycle();
    for (int i = 0; i < 5; i++) begin
      if (i < acc_addr.size()) begin
        chk("basic_addr", 72'(acc_addr[i]), 72'(exp_a[i]));
        chk("basic_tag", 72'(acc_tag[i]), 72'(i));
      end else begin
        chk("basic_accept_missing", 72'(acc_addr.size()), 72'(5));
      end
    end
    chk("basic_fill_wrap", 72'(fill4), 72'(32'h1000_0000));

    // Flow limit: withhold status, then release exactly one
    sts_budget = 0;
    repeat (20) cycle();
    chk("flow_inflight", 72'(q_tag.size()), 72'(MAX_OUT));
    chk("flow_valid_low", 72'(o_cmd_tvalid), 72'(0));
    a0 = accepts;
    sts_budget = 1;
    repeat (10) cycle();
    chk("flow_one_more", 72'(accepts - a0), 72'(1));
    chk("flow_valid_low2", 72'(o_cmd_tvalid), 72'(0));

    // Same-cycle accept and status
    ready_mode = 0; sts_budget = 1;
    repeat (4) cycle();
    chk("sim_pending", 72'(o_cmd_tvalid), 72'(1));
    chk("sim_inflight_pre", 72'(q_tag.size()), 72'(3));
    b0 = o_blocks_done;
    ready_mode = 1; sts_budget = 1;
    cycle();
    chk("sim_inflight", 72'(q_tag.size()), 72'(3));
    chk("sim_blocks", 72'(o_blocks_done), 72'(b0 + 32'd1));
    chk("sim_next_valid", 72'(o_cmd_tvalid), 72'(1));

    // Errors: OKAY+SLVERR, then a wrong tag
    e0 = o_err_count; f0 = o_fill_ptr; s0 = n_sts;
    sts_budget = -1; ready_mode = 2; bad_q.push_back(1); bad_q.push_back(2);
    g = 0;
    while (n_sts < s0 + 2 && g < 60) begin cycle(); g++; end
    chk("err_two_sent", 72'(n_sts - s0), 72'(2));
    chk("err_count_plus2", 72'(o_err_count), 72'(e0 + 16'd2));
    chk("err_sticky", 72'(o_err), 72'(1));
    chk("err_fill_held", 72'(o_fill_ptr), 72'(f0));
    b0 = o_blocks_done;
    repeat (30) cycle();
    chk("err_continues", 72'(o_blocks_done > b0), 72'(1));

    // Stop with 3 outstanding and one command pending
    ready_mode = 0; g = 0;
    while (q_tag.size() > 0 && g < 100) begin cycle(); g++; end
    chk("stop_drained", 72'(q_tag.size()), 72'(0));
    sts_budget = 0; ready_mode = 1; g = 0;
    while (q_tag.size() < 3 && g < 20) begin cycle(); g++; end
    ready_mode = 0;
    i_enable = 1'b0;
    repeat (3) cycle();
    chk("stop_pending_held", 72'(o_cmd_tvalid), 72'(1));
    chk("stop_busy", 72'(o_busy), 72'(1));
    ready_mode = 1;
    cycle();
    ready_mode = 0;
    chk("stop_inflight4", 72'(q_tag.size()), 72'(4));
    repeat (3) cycle();
    chk("stop_no_new_cmd", 72'(o_cmd_tvalid), 72'(0));
    for (int k = 0; k < 4; k++) begin
      chk("stop_busy_wait", 72'(o_busy), 72'(1));
      sts_budget = 1; g = 0;
      while (sts_budget != 0 && g < 20) begin cycle(); g++; end
    end
    g = 0;
    while (o_busy && g < 5) begin cycle(); g++; end
    chk("stop_idle", 72'(o_busy), 72'(0));

    // Randomized runs with random handshakes, latencies and faults
    for (int r = 0; r < 2; r++) begin
      ready_mode = 2; sts_budget = -1; lat_rand = 1; err_pct = 15;
      if (r == 0) begin
        rb = 32'h8000_0000; rbtt = 23'h800; rs = 32'h3000;
      end else begin
        rb = $urandom & 32'hFFFF_F000; rbtt = 23'($urandom_range(1, 4096));
        rs = 32'(rbtt) * 32'($urandom_range(1, 8));
      end
      start(rb, rs, rbtt);
      repeat (300) cycle();
      i_enable = 1'b0; ready_mode = 1; g = 0;
      while (o_busy && g < 200) begin cycle(); g++; end
      chk("rand_idle", 72'(o_busy), 72'(0));
      chk("rand_drained", 72'(q_tag.size()), 72'(0));
    end

    // Asynchronous reset mid-ISSUE
    err_pct = 0;
    start(32'h2000_0000, 32'h0000_2000, 23'h400);
    repeat (15) cycle();
    @(negedge clk);
    i_cmd_tready = 1'b0; i_sts_tvalid = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_cmd_tvalid", 72'(o_cmd_tvalid), 72'(0));
    chk("arst_cmd_tdata", o_cmd_tdata, 72'(0));
    chk("arst_sts_tready", 72'(o_sts_tready), 72'(0));
    chk("arst_busy", 72'(o_busy), 72'(0));
    chk("arst_fill_ptr", 72'(o_fill_ptr), 72'(0));
    chk("arst_blocks", 72'(o_blocks_done), 72'(0));
    chk("arst_err_count", 72'(o_err_count), 72'(0));
    chk("arst_err", 72'(o_err), 72'(0));
    model_clear();
    i_enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    ready_mode = 0;
    repeat (3) cycle();
    chk("post_rst_idle", 72'(o_busy), 72'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
